// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, FSM encodings and parity helper for uart_param.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned PARITY_NONE   = 0;
  localparam int unsigned PARITY_ODD    = 1;
  localparam int unsigned PARITY_EVEN   = 2;

  // Widest payload supported; narrower words are zero-extended into it.
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Parity bit for a zero-extended word; zero padding leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input int unsigned mode);
    logic x;
    x = ^data;
    case (mode)
      PARITY_ODD:  return ~x;
      PARITY_EVEN: return x;
      default:     return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_param_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_param_rx
// Brief    : UART receiver with synchroniser, start-glitch rejection, mid-bit
//            sampling and parity / framing error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module uart_param_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] c_cnt_last  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] c_data_last = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] c_stop_last = IW'(STOP_BITS - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic                 prev_q;
  logic                 w_rx_s;

  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q;
  logic                 ferr_acc_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;

  // Two-flop synchroniser plus a history flop for falling-edge detection; idle-high reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign w_rx_s = sync2_q;

  // Receive sequencer: half-bit start check, then one sample per bit period at mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          // Edge, not level: a line stuck low after a break never re-triggers
          if (prev_q && !w_rx_s) begin
            cnt_q   <= '0;
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q != c_half_last) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (w_rx_s) begin
              state_q <= RX_IDLE;
            end else begin
              idx_q      <= '0;
              ferr_acc_q <= 1'b0;
              state_q    <= RX_DATA;
            end
          end
        end
        default: begin
          if (cnt_q != c_cnt_last) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            case (state_q)
              RX_DATA: begin
                sh_q <= {w_rx_s, sh_q[DATA_BITS-1:1]};
                if (idx_q == c_data_last) begin
                  idx_q <= '0;
                  if (PARITY != PARITY_NONE) state_q <= RX_PARITY;
                  else                       state_q <= RX_STOP;
                end else begin
                  idx_q <= idx_q + 1'b1;
                end
              end
              RX_PARITY: begin
                par_q   <= w_rx_s;
                state_q <= RX_STOP;
              end
              RX_STOP: begin
                if (idx_q == c_stop_last) begin
                  data_q  <= sh_q;
                  valid_q <= 1'b1;
                  perr_q  <= (PARITY != PARITY_NONE) &&
                             (par_q != calc_parity(MAX_DATA_BITS'(sh_q), PARITY));
                  ferr_q  <= ferr_acc_q | ~w_rx_s;
                  state_q <= RX_IDLE;
                end else begin
                  ferr_acc_q <= ferr_acc_q | ~w_rx_s;
                  idx_q      <= idx_q + 1'b1;
                end
              end
              default: state_q <= RX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign rx_data_o       = data_q;
  assign rx_valid_o      = valid_q;
  assign rx_parity_err_o = perr_q;
  assign rx_frame_err_o  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/uart_param_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_param_tx
// Brief    : UART transmitter with valid/ready input and configurable framing.
// Revision : 1.0 - initial release
// ============================================================================
module uart_param_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] c_cnt_last  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] c_data_last = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] c_stop_last = IW'(STOP_BITS - 1);

  tx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 ready_q;

  // Frame sequencer: each bit lasts one full counter sweep; tx and ready are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (tx_valid_i) begin
            sh_q    <= tx_data_i;
            par_q   <= calc_parity(MAX_DATA_BITS'(tx_data_i), PARITY);
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            state_q <= TX_START;
          end
        end
        default: begin
          if (cnt_q != c_cnt_last) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            case (state_q)
              TX_START: begin
                tx_q    <= sh_q[0];
                sh_q    <= sh_q >> 1;
                idx_q   <= '0;
                state_q <= TX_DATA;
              end
              TX_DATA: begin
                if (idx_q == c_data_last) begin
                  idx_q <= '0;
                  if (PARITY != PARITY_NONE) begin
                    tx_q    <= par_q;
                    state_q <= TX_PARITY;
                  end else begin
                    tx_q    <= 1'b1;
                    state_q <= TX_STOP;
                  end
                end else begin
                  tx_q  <= sh_q[0];
                  sh_q  <= sh_q >> 1;
                  idx_q <= idx_q + 1'b1;
                end
              end
              TX_PARITY: begin
                tx_q    <= 1'b1;
                state_q <= TX_STOP;
              end
              TX_STOP: begin
                if (idx_q == c_stop_last) begin
                  ready_q <= 1'b1;
                  state_q <= TX_IDLE;
                end else begin
                  idx_q <= idx_q + 1'b1;
                end
              end
              default: state_q <= TX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = ready_q;

endmodule
`default_nettype wire

// File: rtl/uart_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_param
// Brief    : Parametrised full-duplex UART; wires the TX and RX halves to pins.
// Revision : 1.0 - initial release
// ============================================================================
module uart_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o
);

  uart_param_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY       (PARITY),
    .STOP_BITS    (STOP_BITS)
  ) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .tx_o       (tx_o)
  );

  uart_param_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY       (PARITY),
    .STOP_BITS    (STOP_BITS)
  ) u_rx (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_i            (rx_i),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_parity_err_o (rx_parity_err_o),
    .rx_frame_err_o  (rx_frame_err_o)
  );

`ifndef SYNTHESIS
  a_clks_per_bit: assert property (@(posedge clk) CLKS_PER_BIT >= 4)
    else $error("uart_param: CLKS_PER_BIT must be >= 4");
  a_data_bits: assert property (@(posedge clk) (DATA_BITS >= 5) && (DATA_BITS <= 9))
    else $error("uart_param: DATA_BITS must be 5..9");
  a_parity: assert property (@(posedge clk) PARITY <= PARITY_EVEN)
    else $error("uart_param: PARITY must be 0, 1 or 2");
  a_stop_bits: assert property (@(posedge clk) (STOP_BITS == 1) || (STOP_BITS == 2))
    else $error("uart_param: STOP_BITS must be 1 or 2");
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_param
// Brief    : Directed, table-driven bench for uart_param (main 8E1 instance
//            plus an alternate 7O2 instance in self-loopback).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_param;

  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main instance: 16 clk/bit, 8 data, even parity, 1 stop
  logic [7:0] tx_data  = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx;
  logic       tb_rx    = 1'b1;
  logic       lb       = 1'b0;
  logic       w_rx;
  logic [7:0] rx_data;
  logic       rx_valid, perr, ferr;

  assign w_rx = lb ? tx : tb_rx;

  uart_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_o(tx),
    .rx_i(w_rx), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_parity_err_o(perr), .rx_frame_err_o(ferr)
  );

  // Alternate instance: 7 data, odd parity, 2 stop, looped back on itself
  logic [6:0] a_tx_data  = '0;
  logic       a_tx_valid = 1'b0;
  logic       a_tx_ready, a_tx;
  logic [6:0] a_rx_data;
  logic       a_rx_valid, a_perr, a_ferr;

  uart_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_alt (
    .clk(clk), .rst_n(rst_n),
    .tx_data_i(a_tx_data), .tx_valid_i(a_tx_valid), .tx_ready_o(a_tx_ready), .tx_o(a_tx),
    .rx_i(a_tx), .rx_data_o(a_rx_data), .rx_valid_o(a_rx_valid),
    .rx_parity_err_o(a_perr), .rx_frame_err_o(a_ferr)
  );

  // Received words as {frame_err, parity_err, data}
  logic [9:0] rxq[$];
  logic [9:0] aq[$];

  always @(negedge clk) begin
    if (rx_valid)   rxq.push_back({ferr, perr, rx_data});
    if (a_rx_valid) aq.push_back({a_ferr, a_perr, 1'b0, a_rx_data});
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    tb_rx = b;
    repeat (CPB) tick();
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    tb_rx = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    int k;
    k = 0;
    while (!tx_ready && k < 1000) begin tick(); k++; end
    if (!tx_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send ready timeout: tx_ready=%0b, expected 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic expect_rx(input string name, input bit alt, input logic [7:0] ed,
                           input logic ep, input logic ef, input int budget);
    int k;
    logic [9:0] e;
    k = 0;
    while (((alt ? aq.size() : rxq.size()) == 0) && k < budget) begin tick(); k++; end
    if ((alt ? aq.size() : rxq.size()) == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no rx_valid within %0d cycles, expected one", name, budget);
    end else begin
      e = alt ? aq.pop_front() : rxq.pop_front();
      chk({name, " data"}, {24'd0, e[7:0]}, {24'd0, ed});
      chk({name, " parity_err"}, {31'd0, e[8]}, {31'd0, ep});
      chk({name, " frame_err"}, {31'd0, e[9]}, {31'd0, ef});
    end
  endtask

  // Call right after the acceptance edge (+1): checks every cycle of the frame
  task automatic check_tx_wave(input string name, input logic [15:0] bits,
                               input int nbits, input bit alt);
    int bad, busy;
    logic t, r;
    bad = 0; busy = 0;
    for (int c = 0; c < nbits * CPB; c++) begin
      t = alt ? a_tx : tx;
      r = alt ? a_tx_ready : tx_ready;
      if (t !== bits[c / CPB]) bad++;
      if (r === 1'b0) busy++;
      tick();
    end
    chk({name, " bit errors"}, bad, 0);
    chk({name, " busy cycles"}, busy, nbits * CPB);
    chk({name, " ready after frame"}, {31'd0, alt ? a_tx_ready : tx_ready}, 32'd1);
    chk({name, " line idle after frame"}, {31'd0, alt ? a_tx : tx}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] d;      // payload to drive
    logic       p;      // parity bit to drive
    logic       s;      // stop bit to drive
    logic [7:0] ed;     // expected rx_data
    logic       eperr;  // expected rx_parity_err
    logic       eferr;  // expected rx_frame_err
  } rxvec_t;

  rxvec_t vt[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Even parity: bit = XOR of data bits
    vt[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
    vt[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    vt[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vt[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[5] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    vt[6] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};

    // Reset values
    #3 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("reset rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset errors", {30'd0, perr, ferr}, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();

    // TX frame 0xA5: 0,1,0,1,0,0,1,0,1,p=0,stop=1
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check_tx_wave("tx A5", 16'h054A, 11, 1'b0);

    // Directed RX frames from the table
    for (int i = 0; i < 7; i++) begin
      drive_frame(vt[i].d, vt[i].p, vt[i].s);
      drive_bit(1'b1);
      expect_rx($sformatf("rxvec%0d", i), 1'b0, vt[i].ed, vt[i].eperr, vt[i].eferr, 50);
    end

    // Glitch shorter than half a bit: must not start a frame
    tb_rx = 1'b0;
    repeat (5) tick();
    tb_rx = 1'b1;
    repeat (300) tick();
    chk("glitch rx_valid count", rxq.size(), 0);

    // Break: line low for 20 bit times gives exactly one frame-error word
    tb_rx = 1'b0;
    repeat (20 * CPB) tick();
    chk("break rx_valid count", rxq.size(), 1);
    expect_rx("break", 1'b0, 8'h00, 1'b0, 1'b1, 0);
    tb_rx = 1'b1;
    repeat (2 * CPB) tick();
    drive_frame(8'h55, 1'b0, 1'b1);
    drive_bit(1'b1);
    expect_rx("after break 55", 1'b0, 8'h55, 1'b0, 1'b0, 50);

    // Loopback, back-to-back transfers
    lb = 1'b1;
    repeat (4) tick();
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    expect_rx("lb 00", 1'b0, 8'h00, 1'b0, 1'b0, 600);
    expect_rx("lb FF", 1'b0, 8'hFF, 1'b0, 1'b0, 600);
    expect_rx("lb 3C", 1'b0, 8'h3C, 1'b0, 1'b0, 600);
    repeat (2 * CPB) tick();
    chk("lb no extra words", rxq.size(), 0);

    // Alternate 7O2 config: 0x41 -> parity 1, two stop bits, 11-bit frame
    a_tx_data  = 7'h41;
    a_tx_valid = 1'b1;
    tick();
    a_tx_valid = 1'b0;
    check_tx_wave("alt tx 41", 16'h0782, 11, 1'b1);
    expect_rx("alt lb 41", 1'b1, 8'h41, 1'b0, 1'b0, 200);

    // Reset in the middle of a data bit with TX and RX both busy
    send(8'h96);
    repeat (3 * CPB + 5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset tx", {31'd0, tx}, 32'd1);
    chk("midreset tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("midreset rx_valid", {31'd0, rx_valid}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (300) tick();
    chk("midreset no rx_valid", rxq.size(), 0);
    send(8'h96);
    expect_rx("after reset 96", 1'b0, 8'h96, 1'b0, 1'b0, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_param.md
# uart_param

Parametrised full-duplex UART core: the next generation of the team's simple fixed 8N1 TX/RX pair. Adds configurable data width, parity (none/odd/even), 1 or 2 stop bits, a valid/ready transmit handshake, a synchronised and glitch-filtered receive input, true mid-bit sampling, and parity and framing error reporting. Sits between a byte-stream client (CSR block or FIFO) and the chip pins.

## Interface
- CLKS_PER_BIT, 100, clock cycles per bit; legal range ≥ 4
- DATA_BITS, 8, payload bits per frame; legal range 5..9
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2
- clk  in  1  core clock; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- tx_data  in  DATA_BITS  word to transmit; LSB is sent first
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  transmitter idle; a word is accepted when tx_valid && tx_ready
- tx  out  1  serial output; idles high
- rx  in  1  serial input; asynchronous to clk
- rx_data  out  DATA_BITS  last received word; holds until the next frame completes
- rx_valid  out  1  one-cycle pulse; rx_data and the error flags are valid
- rx_parity_err  out  1  parity mismatch; qualified by rx_valid
- rx_frame_err  out  1  at least one stop bit sampled low; qualified by rx_valid

## Operation
- Reset values: tx = 1, tx_ready = 1, rx_data = 0, rx_valid = 0, both error flags = 0. Both synchroniser flops reset to 1.
- Frame bit count F = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- Odd parity: the parity bit makes the total number of ones (data bits plus parity bit) odd. Even parity: the total is even.
- TX FSM states, in order: IDLE → START → DATA → PARITY → STOP → IDLE.
  - PARITY is skipped when PARITY = 0.
  - STOP lasts STOP_BITS bit periods.
  - tx_ready is high only in IDLE.
  - On acceptance: tx_data is latched and the parity bit is computed from the latched word.
  - tx_valid while not ready is ignored. No queueing.
- RX path:
  - rx passes through a 2-flop synchroniser; call the output rx_s.
  - In IDLE, a start is detected only on a falling edge of rx_s: high in the previous cycle, low in this one. A line held low never triggers a start.
  - START counts to CLKS_PER_BIT/2 − 1, then re-checks rx_s. If high, the start is a glitch: return to IDLE with no output.
  - If rx_s is still low, sample every CLKS_PER_BIT cycles from there: data LSB first, then parity if enabled, then each stop bit. All samples are at mid-bit.
  - After the last stop sample, load rx_data and the error flags, pulse rx_valid for one cycle, and return to IDLE.
- No RX back-pressure: the consumer must capture on rx_valid. A frame with errors still delivers its data.
- Counter width: $clog2(CLKS_PER_BIT). The bit index is wide enough for DATA_BITS. Counters never wrap inside a bit period.

## Timing
- tx_valid && tx_ready high at clock edge k:
  - tx is low from edge k (the cycle after k) onward.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - The last stop bit ends at edge k + F·CLKS_PER_BIT.
  - tx_ready is high from that same edge.
- Back-to-back transfers: a word accepted the first cycle tx_ready is high starts its start bit one cycle later. The stop bit is therefore stretched by at most 1 cycle.
- RX latency: from the rx falling edge to the rx_valid pulse is 2 (synchroniser) + CLKS_PER_BIT/2 + (F − 1)·CLKS_PER_BIT cycles, ±1.
- Reset mid-frame, either direction:
  - Outputs return to their reset values immediately.
  - A partial RX frame is discarded; no rx_valid.
  - A partial TX frame is abandoned; tx goes high.
- Framing error or break: after a frame_err frame, RX re-arms only after a falling edge, i.e. rx_s must first be seen high. A continuous break produces exactly one rx_valid, with rx_frame_err = 1 and rx_data = 0.

## Structure
- Package uart_pkg:
  - PARITY_NONE/ODD/EVEN localparams.
  - TX and RX state encodings.
  - Function computing parity over a DATA_BITS vector for a given mode.
- Sub-modules: uart_param_tx and uart_param_rx. The top level uart_param instantiates both and only wires ports.
- Parameter-legality checks are simulation-only assertions in the top level.

## Test plan
- Configuration: CLKS_PER_BIT = 16, DATA_BITS = 8, PARITY = 2, STOP_BITS = 1, unless stated otherwise.
- TX frame: send 0xA5 → tx shows 0, 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit 16 cycles; tx_ready low for exactly 176 cycles.
- Loopback (tx → rx): send 0x00, 0xFF, 0x3C back-to-back → three rx_valid pulses with matching data; both error flags 0.
- Parity error: drive a 0xA5 frame with parity bit 1 → rx_valid with rx_data = 0xA5 and rx_parity_err = 1. Framing error: stop bit driven 0 → rx_frame_err = 1.
- Glitch and break:
  - rx low for 5 cycles → no rx_valid.
  - rx held low for 20 bit times → exactly one rx_valid with rx_frame_err = 1.
  - Then a 0x55 frame after the line returns high → received correctly.
- Alternate configuration DATA_BITS = 7, PARITY = 1, STOP_BITS = 2: send 0x41 → parity bit 1, two stop bits, frame 11 bits; loopback rx_data = 0x41.
- Reset asserted mid-data-bit on both TX and RX → tx = 1 and tx_ready = 1 immediately, no rx_valid. A following 0x96 transfer completes correctly.
